mm_stream_to_burst_write: RTL and testbench

MM_STREAM_TO_BURST_WRITE -- requirements
Module: mm_stream_to_burst_write

---
 rtl/mm_burst_pkg.sv | 15 +
 rtl/line_pingpong_ram.sv | 30 +++
 rtl/mm_stream_to_burst_write.sv | 164 ++++++++++++++++
 tb/tb_mm_stream_to_burst_write.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_burst_pkg.sv
// Shared constants and FSM encoding for the stream-to-burst line writer.
package mm_burst_pkg;

  localparam int LINE_DEPTH_DEF = 160;
  localparam int ADDR_W         = 23;
  localparam int PIX_W          = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    BURST     = 2'd2,
    WAIT_DONE = 2'd3
  } burstState_e;

endpackage

// File: rtl/line_pingpong_ram.sv
// Two line buffers in one array: buffer 0 at 0..LINE_DEPTH-1, buffer 1 above it.
module line_pingpong_ram
  import mm_burst_pkg::*;
#(
  parameter int LINE_DEPTH = LINE_DEPTH_DEF,
  parameter int AW         = $clog2(2 * LINE_DEPTH)
) (
  input  logic             xClk,
  input  logic             xRst_n,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [PIX_W-1:0] wrData,
  input  logic             rdEn,
  input  logic [AW-1:0]    rdAddr,
  output logic [PIX_W-1:0] rdData
);

  logic [PIX_W-1:0] mem [2*LINE_DEPTH];

  always_ff @(posedge xClk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // Output register keeps its reset so the write-data port idles at zero.
  always_ff @(posedge xClk) begin
    if (!xRst_n)   rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/mm_stream_to_burst_write.sv
// Captures video lines into ping-pong buffers and drains each as one burst write.
// Optional MM_WR_DROP_CNT_EN enables the saturating dropped-line counter.
module mm_stream_to_burst_write
  import mm_burst_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_POINTER = 23'h0,
  parameter int                LINE_DEPTH   = LINE_DEPTH_DEF
) (
  input  logic              xClk,
  input  logic              xRst_n,
  input  logic              xVsync,
  input  logic              xHsync,
  input  logic              xValid,
  input  logic [PIX_W-1:0]  xPixel,
  input  logic              xRamReady,
  input  logic              xWrDataReq,
  input  logic              xWrBurstDone,
  output logic              xGbReqWrite,
  output logic [ADDR_W-1:0] xGbAddress,
  output logic [PIX_W-1:0]  xWrData,
  output logic              xOverflow,
  output logic [7:0]        xDropCnt
);

  localparam int IDX_W  = $clog2(LINE_DEPTH + 1);
  localparam int RAM_AW = $clog2(2 * LINE_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_DEPTH - 1);
  localparam logic [IDX_W-1:0]  DEPTH_IDX = IDX_W'(LINE_DEPTH);
  localparam logic [RAM_AW-1:0] BUF1_OFS  = RAM_AW'(LINE_DEPTH);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(2 * LINE_DEPTH);

  logic              vsyncReg, hsyncReg;
  logic              sof, lineStart, lineEnd;
  logic [IDX_W-1:0]  capIdxReg, wrIdx;
  logic              capBufReg;
  logic [1:0]        fullReg, fullNext;
  logic [ADDR_W-1:0] lineAddrReg;
  logic [ADDR_W-1:0] bufAddrReg [2];
  logic              overflowReg;
  logic              ramWrEn, ramRdEn, freeBuf, dropLine, commitLine;
  logic [RAM_AW-1:0] ramWrAddr, ramRdAddr;

  burstState_e       stateReg, stateNext;
  logic [IDX_W-1:0]  popCntReg, popCntNext;
  logic              drainBufReg, drainBufNext;
  logic              reqReg, reqNext;
  logic [ADDR_W-1:0] addrReg, addrNext;

  assign sof       = xVsync & ~vsyncReg;
  assign lineStart = xHsync & ~hsyncReg;
  assign lineEnd   = ~xHsync & hsyncReg;

  // A full capture buffer is still owed to the controller, so its contents are protected.
  assign wrIdx      = (sof | lineStart) ? '0 : capIdxReg;
  assign ramWrEn    = xValid && (wrIdx < DEPTH_IDX) && !fullReg[capBufReg];
  assign ramWrAddr  = (capBufReg ? BUF1_OFS : '0) + RAM_AW'(wrIdx);
  assign ramRdAddr  = (drainBufReg ? BUF1_OFS : '0) + RAM_AW'(popCntReg);

  assign freeBuf    = (stateReg == WAIT_DONE) && xWrBurstDone;
  assign dropLine   = lineEnd && (capIdxReg != '0) && fullReg[capBufReg]
                      && !(freeBuf && (drainBufReg == capBufReg));
  assign commitLine = lineEnd && (capIdxReg != '0) && !dropLine;

  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign fullNext[gi] = (fullReg[gi] & ~(freeBuf && (drainBufReg == 1'(gi))))
                          | (commitLine && (capBufReg == 1'(gi)));
  end

  always_ff @(posedge xClk) begin
    if (!xRst_n) begin
      vsyncReg    <= 1'b0;
      hsyncReg    <= 1'b0;
      capIdxReg   <= '0;
      capBufReg   <= 1'b0;
      fullReg     <= '0;
      lineAddrReg <= BASE_POINTER;
      overflowReg <= 1'b0;
    end else begin
      vsyncReg  <= xVsync;
      hsyncReg  <= xHsync;
      fullReg   <= fullNext;
      capIdxReg <= (xValid && (wrIdx < DEPTH_IDX)) ? wrIdx + 1'b1 : wrIdx;
      if (commitLine) capBufReg <= ~capBufReg;
      if (sof)             lineAddrReg <= BASE_POINTER;
      else if (commitLine) lineAddrReg <= lineAddrReg + LINE_STEP;
      if (dropLine) overflowReg <= 1'b1;
    end
  end

  always_ff @(posedge xClk) begin
    if (commitLine) bufAddrReg[capBufReg] <= lineAddrReg;
  end

`ifdef MM_WR_DROP_CNT_EN
  logic [7:0] dropCntReg;
  always_ff @(posedge xClk) begin
    if (!xRst_n)                              dropCntReg <= 8'd0;
    else if (dropLine && dropCntReg != 8'hFF) dropCntReg <= dropCntReg + 8'd1;
  end
  assign xDropCnt = dropCntReg;
`else
  assign xDropCnt = 8'd0;
`endif

  always_ff @(posedge xClk) begin
    if (!xRst_n) begin
      stateReg    <= IDLE;
      popCntReg   <= '0;
      drainBufReg <= 1'b0;
      reqReg      <= 1'b0;
      addrReg     <= BASE_POINTER;
    end else begin
      stateReg    <= stateNext;
      popCntReg   <= popCntNext;
      drainBufReg <= drainBufNext;
      reqReg      <= reqNext;
      addrReg     <= addrNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    popCntNext   = popCntReg;
    drainBufNext = drainBufReg;
    reqNext      = 1'b0;
    addrNext     = addrReg;
    ramRdEn      = 1'b0;
    case (stateReg)
      IDLE: if (fullReg[drainBufReg]) stateNext = REQ;
      REQ: if (xRamReady) begin
        reqNext    = 1'b1;
        addrNext   = bufAddrReg[drainBufReg];
        popCntNext = '0;
        stateNext  = BURST;
      end
      BURST: if (xWrDataReq) begin
        ramRdEn    = 1'b1;
        popCntNext = popCntReg + 1'b1;
        if (popCntReg == LAST_IDX) stateNext = WAIT_DONE;
      end
      WAIT_DONE: if (xWrBurstDone) begin
        drainBufNext = ~drainBufReg;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  line_pingpong_ram #(.LINE_DEPTH(LINE_DEPTH), .AW(RAM_AW)) uRam (
    .xClk   (xClk),
    .xRst_n (xRst_n),
    .wrEn   (ramWrEn),
    .wrAddr (ramWrAddr),
    .wrData (xPixel),
    .rdEn   (ramRdEn),
    .rdAddr (ramRdAddr),
    .rdData (xWrData)
  );

  assign xGbReqWrite = reqReg;
  assign xGbAddress  = addrReg;
  assign xOverflow   = overflowReg;

endmodule

// File: tb/tb_mm_stream_to_burst_write.sv
// Directed bench: line table plus hand sequences for overflow, SOF mid-burst and reset.
module tb_mm_stream_to_burst_write;
  import mm_burst_pkg::*;

  localparam int LD = 160;
`ifdef MM_WR_DROP_CNT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  logic        xClk = 1'b0;
  logic        xRst_n, xVsync, xHsync, xValid, xRamReady, xWrDataReq, xWrBurstDone;
  logic [15:0] xPixel, xWrData;
  logic        xGbReqWrite, xOverflow;
  logic [22:0] xGbAddress;
  logic [7:0]  xDropCnt;

  always #5 xClk = ~xClk;

  mm_stream_to_burst_write dut (
    .xClk(xClk), .xRst_n(xRst_n), .xVsync(xVsync), .xHsync(xHsync), .xValid(xValid),
    .xPixel(xPixel), .xRamReady(xRamReady), .xWrDataReq(xWrDataReq),
    .xWrBurstDone(xWrBurstDone), .xGbReqWrite(xGbReqWrite), .xGbAddress(xGbAddress),
    .xWrData(xWrData), .xOverflow(xOverflow), .xDropCnt(xDropCnt)
  );

  typedef struct {
    int nPix;
    int base;
    int expAddr;
    int staleBase;
  } vec_t;

  int nCompared = 0, nMismatched = 0;
  int reqCount = 0, burstsDone = 0, expReq = 0, expBursts = 0;
  bit ctrlAbort = 1'b0;
  logic [22:0] addrLog [16];
  logic [15:0] wordsLog [16][LD];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory-controller model: pops LINE_DEPTH words per request, then pulses done.
  initial begin : ctrl
    logic [22:0] a;
    bit aborted;
    xWrDataReq = 1'b0;
    xWrBurstDone = 1'b0;
    forever begin
      @(negedge xClk);
      if (xGbReqWrite === 1'b1) begin
        reqCount++;
        a = xGbAddress;
        aborted = 1'b0;
        xWrDataReq = 1'b1;
        for (int k = 0; k < LD; k++) begin
          @(negedge xClk);
          if (ctrlAbort) begin
            aborted = 1'b1;
            break;
          end
          if (k == 0) check("req_one_cycle", 32'(xGbReqWrite), 0);
          if (burstsDone < 16) wordsLog[burstsDone][k] = xWrData;
          xWrDataReq = (k < LD - 1);
        end
        xWrDataReq = 1'b0;
        if (!aborted && burstsDone < 16) begin
          xWrDataReq = 1'b1;
          repeat (2) @(negedge xClk);
          xWrDataReq = 1'b0;
          @(negedge xClk);
          check("pop_beyond_depth", 32'(xWrData), 32'(wordsLog[burstsDone][LD-1]));
          check("addr_stable", 32'(xGbAddress), 32'(a));
          xWrBurstDone = 1'b1;
          @(negedge xClk);
          xWrBurstDone = 1'b0;
          addrLog[burstsDone] = a;
          burstsDone++;
        end
      end
    end
  end

  task automatic sendSof();
    @(negedge xClk); xVsync = 1'b1;
    repeat (2) @(negedge xClk);
    xVsync = 1'b0;
    repeat (2) @(negedge xClk);
  endtask

  task automatic sendLine(input int n, input int base);
    @(negedge xClk); xHsync = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge xClk);
      xValid = 1'b1;
      xPixel = 16'(base + i);
    end
    @(negedge xClk);
    xValid = 1'b0;
    xHsync = 1'b0;
    repeat (3) @(negedge xClk);
  endtask

  task automatic waitBursts(input string name);
    int t = 0;
    while (burstsDone < expBursts && t < 3000) begin
      @(negedge xClk);
      t++;
    end
    check({name, "_bursts"}, 32'(burstsDone), 32'(expBursts));
  endtask

  task automatic waitReq(input string name);
    int t = 0;
    while (reqCount < expReq && t < 3000) begin
      @(negedge xClk);
      t++;
    end
    check({name, "_req"}, 32'(reqCount), 32'(expReq));
  endtask

  task automatic checkBurst(input string name, input int idx, input int expAddr,
                            input int nPix, input int base, input int staleBase);
    int bad = 0;
    logic [15:0] e;
    check({name, "_addr"}, 32'(addrLog[idx]), 32'(expAddr));
    for (int k = 0; k < LD; k++) begin
      if (k < nPix) e = 16'(base + k);
      else if (staleBase < 0) continue;
      else e = 16'(staleBase + k);
      if (wordsLog[idx][k] !== e) bad++;
    end
    check({name, "_bad_words"}, 32'(bad), 0);
  endtask

  task automatic checkResetOuts(input string name);
    check({name, "_req"},      32'(xGbReqWrite), 0);
    check({name, "_addr"},     32'(xGbAddress), 0);
    check({name, "_wrdata"},   32'(xWrData), 0);
    check({name, "_overflow"}, 32'(xOverflow), 0);
    check({name, "_dropcnt"},  32'(xDropCnt), 0);
    check({name, "_fsm"},      32'(dut.stateReg), 32'(IDLE));
  endtask

  initial begin : main
    vec_t tbl [5];
    tbl[0] = '{nPix: 160, base: 0,    expAddr: 0,    staleBase: -1};
    tbl[1] = '{nPix: 160, base: 1000, expAddr: 320,  staleBase: -1};
    tbl[2] = '{nPix: 160, base: 2000, expAddr: 640,  staleBase: -1};
    tbl[3] = '{nPix: 200, base: 3000, expAddr: 960,  staleBase: -1};
    tbl[4] = '{nPix: 50,  base: 5000, expAddr: 1280, staleBase: 2000};

    xRst_n = 1'b0; xVsync = 1'b0; xHsync = 1'b0; xValid = 1'b0;
    xPixel = 16'd0; xRamReady = 1'b1;
    repeat (3) @(negedge xClk);
    checkResetOuts("reset");
    xRst_n = 1'b1;
    repeat (2) @(negedge xClk);

    // Lines in one frame, each drained before the next arrives.
    sendSof();
    for (int r = 0; r < 5; r++) begin
      sendLine(tbl[r].nPix, tbl[r].base);
      expReq++;
      expBursts++;
      waitBursts($sformatf("line%0d", r));
      checkBurst($sformatf("line%0d", r), expBursts - 1, tbl[r].expAddr,
                 (tbl[r].nPix > LD) ? LD : tbl[r].nPix, tbl[r].base, tbl[r].staleBase);
      check($sformatf("line%0d_reqs", r), 32'(reqCount), 32'(expReq));
      $display("line %0d: %0d pixels, burst at %0d", r, tbl[r].nPix, addrLog[expBursts-1]);
    end

    // Controller stalled for three lines: two buffered, third dropped.
    sendSof();
    xRamReady = 1'b0;
    sendLine(160, 100);
    sendLine(160, 200);
    sendLine(160, 300);
    repeat (5) @(negedge xClk);
    check("ovf_no_request", 32'(reqCount), 32'(expReq));
    check("ovf_flag", 32'(xOverflow), 1);
    check("ovf_dropcnt", 32'(xDropCnt), 32'(EXP_DROP));
    xRamReady = 1'b1;
    expReq += 2;
    expBursts += 2;
    waitBursts("ovf");
    checkBurst("ovf_l1", expBursts - 2, 0, 160, 100, -1);
    checkBurst("ovf_l2", expBursts - 1, 320, 160, 200, -1);
    check("ovf_reqs", 32'(reqCount), 32'(expReq));
    check("ovf_sticky", 32'(xOverflow), 1);
    $display("overflow: drop count %0d, drained bursts at 0 and 320", xDropCnt);

    // SOF while a non-base burst is draining.
    sendSof();
    sendLine(160, 400);
    expReq++;
    expBursts++;
    waitBursts("sof_a");
    checkBurst("sof_a", expBursts - 1, 0, 160, 400, -1);
    sendLine(160, 500);
    expReq++;
    waitReq("sof_b");
    repeat (5) @(negedge xClk);
    check("sof_burst_in_flight", 32'(burstsDone), 32'(expBursts));
    sendSof();
    sendLine(40, 600);
    expReq++;
    expBursts += 2;
    waitBursts("sof_mid");
    checkBurst("sof_old", expBursts - 2, 320, 160, 500, -1);
    checkBurst("sof_new", expBursts - 1, 0, 40, 600, -1);
    check("sof_reqs", 32'(reqCount), 32'(expReq));
    $display("sof mid-burst: old burst at %0d, next at %0d", addrLog[expBursts-2], addrLog[expBursts-1]);

    // One-cycle reset in the middle of a burst at a non-base address.
    sendSof();
    sendLine(160, 700);
    expReq++;
    expBursts++;
    waitBursts("rst_a");
    checkBurst("rst_a", expBursts - 1, 0, 160, 700, -1);
    sendLine(160, 800);
    expReq++;
    waitReq("rst_b");
    repeat (10) @(negedge xClk);
    ctrlAbort = 1'b1;
    xRst_n = 1'b0;
    @(negedge xClk);
    xRst_n = 1'b1;
    checkResetOuts("midrst");
    repeat (3) @(negedge xClk);
    ctrlAbort = 1'b0;
    repeat (20) @(negedge xClk);
    check("midrst_no_request", 32'(reqCount), 32'(expReq));
    sendLine(160, 900);
    expReq++;
    expBursts++;
    waitBursts("post_rst");
    checkBurst("post_rst", expBursts - 1, 0, 160, 900, -1);
    $display("reset mid-burst: recovered, next burst at %0d", addrLog[expBursts-1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
